// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: shared state encoding, BCD limits and BCD helpers for the set-time controller.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

    function automatic logic [7:0] bcd_clean(input logic [7:0] v, input logic [7:0] max);
        return (v > max || v[3:0] > 4'd9) ? 8'h00 : v;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        return (v == max) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-level debouncer and 1-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk0,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    logic [1:0]  r_sync;
    logic        r_level;
    logic        r_press;
    logic [31:0] r_cnt;
    logic        w_diff;
    logic        w_accept;

    assign w_diff   = r_sync[1] != r_level;
    assign w_accept = w_diff && r_cnt == DEB_CYCLES - 1;
    assign o_level  = r_level;
    assign o_press  = r_press;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= w_accept && r_sync[1];
            r_level <= w_accept ? r_sync[1] : r_level;
            r_cnt   <= (!w_diff || w_accept) ? '0 : r_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven set-time FSM for the 24 h clock; edits BCD hour/minute,
// strobes a load into the counters, freezes them while editing and drives the digit blink mask.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned REPEAT_DLY  = 25000000,
    parameter int unsigned REPEAT_RATE = 5000000,
    parameter int unsigned BLINK_HALF  = 12500000,
    parameter int unsigned TIMEOUT_CYC = 500000000
) (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic       btn_mode_raw,
    input  logic       btn_inc_raw,
    input  logic [7:0] cur_hour_bcd,
    input  logic [7:0] cur_min_bcd,
    output logic [7:0] set_hour_bcd,
    output logic [7:0] set_min_bcd,
    output logic       load,
    output logic       run_en,
    output logic [3:0] blink_mask,
    output logic [1:0] mode
);

    state_t      r_state, w_nstate;
    logic [7:0]  r_hour, r_min, w_nhour, w_nmin;
    logic [31:0] r_rep_cnt, w_nrep_cnt;
    logic        r_rep_act, r_rep_first, w_nrep_act, w_nrep_first;
    logic [31:0] r_to_cnt, w_nto_cnt;
    logic [31:0] r_blk_cnt, w_nblk_cnt;
    logic        r_phase, w_nphase;
    logic        r_load, r_run_en;
    logic [3:0]  r_blink, w_nblink;
    logic        w_mode_level, w_mode_press, w_inc_level, w_inc_press;
    logic        w_mode_ev, w_inc_ev, w_rep_fire, w_timeout, w_edit, w_state_chg, w_blk_wrap;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
        .clk0    (clk0),
        .rst_n   (rst_n),
        .i_btn   (btn_mode_raw),
        .o_level (w_mode_level),
        .o_press (w_mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
        .clk0    (clk0),
        .rst_n   (rst_n),
        .i_btn   (btn_inc_raw),
        .o_level (w_inc_level),
        .o_press (w_inc_press)
    );

    assign w_edit      = r_state != ST_RUN;
    assign w_mode_ev   = w_mode_press && w_mode_level;
    assign w_rep_fire  = r_rep_act && w_inc_level && r_rep_cnt == (r_rep_first ? REPEAT_DLY : REPEAT_RATE);
    assign w_inc_ev    = w_edit && (w_inc_press || w_rep_fire);
    assign w_timeout   = w_edit && r_to_cnt == TIMEOUT_CYC - 1;

    // Mode events take priority; a simultaneous increment is dropped.
    always_comb begin
        w_nstate = r_state;
        w_nhour  = r_hour;
        w_nmin   = r_min;
        if (w_mode_ev) begin
            w_nstate = (r_state == ST_RUN) ? ST_SET_HOUR : (r_state == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
            w_nhour  = (r_state == ST_RUN) ? bcd_clean(cur_hour_bcd, HOUR_MAX_BCD) : r_hour;
            w_nmin   = (r_state == ST_RUN) ? bcd_clean(cur_min_bcd, MIN_MAX_BCD) : r_min;
        end else if (w_inc_ev) begin
            w_nhour = (r_state == ST_SET_HOUR) ? bcd_inc(r_hour, HOUR_MAX_BCD) : r_hour;
            w_nmin  = (r_state == ST_SET_MIN) ? bcd_inc(r_min, MIN_MAX_BCD) : r_min;
        end else if (w_timeout) begin
            w_nstate = ST_RUN;
        end
    end

    always_comb begin
        w_nrep_act   = r_rep_act && w_inc_level && w_edit && !w_mode_ev;
        w_nrep_first = r_rep_first;
        w_nrep_cnt   = r_rep_cnt + 32'd1;
        if (w_edit && w_inc_press && !w_mode_ev) begin
            w_nrep_act   = 1'b1;
            w_nrep_first = 1'b1;
            w_nrep_cnt   = 32'd1;
        end else if (w_rep_fire) begin
            w_nrep_first = 1'b0;
            w_nrep_cnt   = 32'd1;
        end
    end

    assign w_nto_cnt   = (!w_edit || w_mode_ev || w_inc_ev || w_timeout) ? '0 : r_to_cnt + 32'd1;
    assign w_state_chg = w_nstate != r_state;
    assign w_blk_wrap  = r_blk_cnt == BLINK_HALF - 1;
    assign w_nblk_cnt  = (w_state_chg || w_blk_wrap) ? '0 : r_blk_cnt + 32'd1;
    assign w_nphase    = !w_state_chg && (r_phase ^ w_blk_wrap);
    assign w_nblink    = !w_nphase ? 4'b0000 : (w_nstate == ST_SET_HOUR) ? 4'b1100 :
                         (w_nstate == ST_SET_MIN) ? 4'b0011 : 4'b0000;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_hour      <= 8'h00;
            r_min       <= 8'h00;
            r_rep_cnt   <= '0;
            r_rep_act   <= 1'b0;
            r_rep_first <= 1'b0;
            r_to_cnt    <= '0;
            r_blk_cnt   <= '0;
            r_phase     <= 1'b0;
            r_load      <= 1'b0;
            r_run_en    <= 1'b1;
            r_blink     <= 4'b0000;
        end else begin
            r_state     <= w_nstate;
            r_hour      <= w_nhour;
            r_min       <= w_nmin;
            r_rep_cnt   <= w_nrep_cnt;
            r_rep_act   <= w_nrep_act;
            r_rep_first <= w_nrep_first;
            r_to_cnt    <= w_nto_cnt;
            r_blk_cnt   <= w_nblk_cnt;
            r_phase     <= w_nphase;
            r_load      <= w_mode_ev && r_state == ST_SET_MIN;
            r_run_en    <= w_nstate == ST_RUN;
            r_blink     <= w_nblink;
        end
    end

    // Edit registers double as set_* outputs: they hold the committed value until the next capture.
    assign set_hour_bcd = r_hour;
    assign set_min_bcd  = r_min;
    assign load         = r_load;
    assign run_en       = r_run_en;
    assign blink_mask   = r_blink;
    assign mode         = r_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed self-checking bench for time_set_ctrl with shortened timing parameters.
module tb_time_set_ctrl;

    logic       clk0 = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode_raw = 1'b0;
    logic       btn_inc_raw = 1'b0;
    logic [7:0] cur_hour_bcd = 8'h00;
    logic [7:0] cur_min_bcd = 8'h00;
    logic [7:0] set_hour_bcd, set_min_bcd;
    logic       load, run_en;
    logic [3:0] blink_mask;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail = 0;
    int load_cnt = 0;
    int mode_chg = 0;
    int run_bad = 0;
    logic [7:0] ld_h = 8'h00;
    logic [7:0] ld_m = 8'h00;
    logic [1:0] prev_mode = 2'd0;

    time_set_ctrl #(
        .DEB_CYCLES  (4),
        .REPEAT_DLY  (20),
        .REPEAT_RATE (5),
        .BLINK_HALF  (8),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk0         (clk0),
        .rst_n        (rst_n),
        .btn_mode_raw (btn_mode_raw),
        .btn_inc_raw  (btn_inc_raw),
        .cur_hour_bcd (cur_hour_bcd),
        .cur_min_bcd  (cur_min_bcd),
        .set_hour_bcd (set_hour_bcd),
        .set_min_bcd  (set_min_bcd),
        .load         (load),
        .run_en       (run_en),
        .blink_mask   (blink_mask),
        .mode         (mode)
    );

    always #5 clk0 = ~clk0;

    always @(negedge clk0) begin
        if (load) begin
            load_cnt = load_cnt + 1;
            ld_h = set_hour_bcd;
            ld_m = set_min_bcd;
        end
        if (mode != 2'd0 && run_en) run_bad = run_bad + 1;
        if (mode != prev_mode) mode_chg = mode_chg + 1;
        prev_mode = mode;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_mode_raw = 1'b0;
        btn_inc_raw = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        load_cnt = 0;
        mode_chg = 0;
        run_bad = 0;
        prev_mode = 2'd0;
    endtask

    // Holds the raw buttons long enough for one debounced press, then releases fully.
    task automatic pulse(input logic m, input logic i);
        btn_mode_raw = m;
        btn_inc_raw = i;
        repeat (8) tick();
        btn_mode_raw = 1'b0;
        btn_inc_raw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_mode", mode, 0);
        check("rst_run_en", run_en, 1);
        check("rst_load", load, 0);
        check("rst_set_hour", set_hour_bcd, 8'h00);
        check("rst_set_min", set_min_bcd, 8'h00);
        check("rst_blink", blink_mask, 0);

        cur_hour_bcd = 8'h12;
        cur_min_bcd = 8'h34;
        for (int i = 0; i < 6; i++) begin
            btn_mode_raw = ~btn_mode_raw;
            repeat (2) tick();
        end
        check("bounce_mode_early", mode, 0);
        btn_mode_raw = 1'b1;
        for (int n = 0; n < 7 && mode != 2'd1; n++) tick();
        check("bounce_mode", mode, 1);
        repeat (5) tick();
        btn_mode_raw = 1'b0;
        repeat (10) tick();
        check("bounce_events", mode_chg, 1);

        do_reset();
        pulse(1, 0);
        check("edit_blink_hour", blink_mask, 4'b1100);
        check("edit_run_en", run_en, 0);
        for (int i = 0; i < 3; i++) pulse(0, 1);
        pulse(1, 0);
        check("edit_blink_min", blink_mask, 4'b0011);
        for (int i = 0; i < 30; i++) pulse(0, 1);
        pulse(1, 0);
        check("edit_load_cnt", load_cnt, 1);
        check("edit_load_hour", ld_h, 8'h15);
        check("edit_load_min", ld_m, 8'h04);
        check("edit_run_en_bad", run_bad, 0);
        check("edit_mode_end", mode, 0);
        check("edit_run_en_end", run_en, 1);
        check("edit_blink_end", blink_mask, 0);

        do_reset();
        cur_hour_bcd = 8'h23;
        cur_min_bcd = 8'h59;
        pulse(1, 0);
        check("wrap_cap_hour", set_hour_bcd, 8'h23);
        pulse(0, 1);
        check("wrap_hour", set_hour_bcd, 8'h00);
        pulse(1, 0);
        pulse(0, 1);
        check("wrap_min", set_min_bcd, 8'h00);
        pulse(1, 0);
        check("wrap_load_cnt", load_cnt, 1);
        check("wrap_load_hm", {ld_h, ld_m}, 16'h0000);
        cur_hour_bcd = 8'h2A;
        cur_min_bcd = 8'h1B;
        pulse(1, 0);
        check("bad_cap_hour", set_hour_bcd, 8'h00);
        check("bad_cap_min", set_min_bcd, 8'h00);
        pulse(1, 0);
        pulse(1, 0);
        cur_hour_bcd = 8'h09;
        cur_min_bcd = 8'h09;
        pulse(1, 0);
        pulse(0, 1);
        check("carry_hour", set_hour_bcd, 8'h10);
        pulse(1, 0);
        pulse(0, 1);
        check("carry_min", set_min_bcd, 8'h10);

        do_reset();
        cur_hour_bcd = 8'h00;
        cur_min_bcd = 8'h58;
        pulse(1, 0);
        pulse(1, 0);
        check("rep_start", set_min_bcd, 8'h58);
        btn_inc_raw = 1'b1;
        for (int n = 0; n < 10 && set_min_bcd != 8'h59; n++) tick();
        check("rep_press", set_min_bcd, 8'h59);
        repeat (19) tick();
        check("rep_before_dly", set_min_bcd, 8'h59);
        tick();
        check("rep_dly", set_min_bcd, 8'h00);
        repeat (5) tick();
        check("rep_rate1", set_min_bcd, 8'h01);
        repeat (5) tick();
        check("rep_rate2", set_min_bcd, 8'h02);
        repeat (10) tick();
        btn_inc_raw = 1'b0;
        repeat (30) tick();
        check("rep_stop", set_min_bcd, 8'h05);
        check("rep_mode", mode, 2);

        do_reset();
        cur_hour_bcd = 8'h10;
        cur_min_bcd = 8'h20;
        pulse(1, 0);
        pulse(1, 1);
        check("sim_mode", mode, 2);
        check("sim_hour", set_hour_bcd, 8'h10);
        check("sim_min", set_min_bcd, 8'h20);
        repeat (90) tick();
        check("to_before", mode, 2);
        tick();
        check("to_mode", mode, 0);
        repeat (5) tick();
        check("to_run_en", run_en, 1);
        check("to_no_load", load_cnt, 0);

        do_reset();
        cur_hour_bcd = 8'h11;
        cur_min_bcd = 8'h22;
        pulse(1, 0);
        pulse(1, 0);
        check("rst_mid_pre", {mode, blink_mask}, {2'd2, 4'b0011});
        rst_n = 1'b0;
        #1;
        check("rst_mid_mode", mode, 0);
        check("rst_mid_run_en", run_en, 1);
        check("rst_mid_hm", {set_hour_bcd, set_min_bcd}, 16'h0000);
        check("rst_mid_blink", blink_mask, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("rst_mid_no_load", load_cnt, 0);
        check("rst_mid_mode_after", mode, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
